// File: rtl/lpf_mc.sv
`default_nettype none
// ============================================================================
// Module      : lpf_mc
// Description : Multi-channel, time-multiplexed one-pole low-pass filter,
//               y[n] = y[n-1] + alpha*(x[n]-y[n-1]), with one shared
//               multiplier, per-channel state array, run-time alpha,
//               valid/ready handshakes on both sides and saturating output.
//               Optional feature macro: LPF_MC_SATFLAG_EN (adds sticky
//               per-channel saturation flags on port sat_flags).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               alpha [SCALE+1]     - unsigned coefficient, 2^SCALE = 1.0
//               clr_all             - synchronous clear of all channel states
//               in_valid/in_ready   - input handshake
//               in_ch, in_data      - input channel index and signed sample
//               out_valid/out_ready - output handshake
//               out_ch, out_data    - output channel index and signed result
//               sat_flags [NCH]     - sticky saturation flags (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module lpf_mc #(
    parameter int WIDTH = 10,
    parameter int SCALE = 15,
    parameter int NCH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SCALE:0]            alpha,
    input  logic                      clr_all,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(NCH)-1:0]    in_ch,
    input  logic signed [WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NCH)-1:0]    out_ch,
    output logic signed [WIDTH-1:0]   out_data
`ifdef LPF_MC_SATFLAG_EN
    ,
    output logic [NCH-1:0]            sat_flags
`endif
);

    localparam int CH_W = $clog2(NCH);
    localparam int PW   = WIDTH + SCALE + 3;   // product width
    localparam int AW   = WIDTH + 3;           // accumulator width

    localparam logic [CH_W:0]           C_NCH  = (CH_W+1)'(NCH);
    localparam logic signed [PW-1:0]    C_HALF = {{(PW-SCALE){1'b0}}, 1'b1, {(SCALE-1){1'b0}}};
    localparam logic signed [AW-1:0]    C_MAX  = {4'b0000, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0]    C_MIN  = {4'b1111, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                    w_accept;
    logic                    w_calc;
    logic                    w_ch_ok;

    logic [CH_W-1:0]         r_ch;
    logic signed [WIDTH-1:0] r_x;
    logic [SCALE:0]          r_alpha;
    logic signed [WIDTH-1:0] r_y [NCH];

    logic signed [WIDTH-1:0] w_y_cur;
    logic signed [WIDTH:0]   w_diff;
    logic signed [PW-1:0]    w_diff_ext;
    logic signed [PW-1:0]    w_alpha_ext;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_round;
    logic signed [AW-1:0]    w_scaled;
    logic signed [AW-1:0]    w_acc;
    logic signed [WIDTH-1:0] w_res;
    logic                    w_sat;
    logic                    w_unused_round;

    // Out-of-range channels are accepted but never enter CALC.
    assign w_ch_ok = ({1'b0, in_ch} < C_NCH);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        w_calc       = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                // A sample coinciding with clr_all is not taken.
                if (in_valid && !clr_all) begin
                    w_accept = 1'b1;
                    if (w_ch_ok) begin
                        w_state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_calc       = 1'b1;
                w_state_next = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (clr_all) begin
            w_state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Shared datapath: one multiplier, round-half-up, clamp
    // ------------------------------------------------------------------
    always_comb begin
        w_y_cur     = r_y[r_ch];
        w_diff      = {r_x[WIDTH-1], r_x} - {w_y_cur[WIDTH-1], w_y_cur};
        w_diff_ext  = {{(PW-WIDTH-1){w_diff[WIDTH]}}, w_diff};
        w_alpha_ext = {{(PW-SCALE-1){1'b0}}, r_alpha};
        w_prod      = w_diff_ext * w_alpha_ext;
        w_round     = w_prod + C_HALF;
        // Top AW bits of the rounded product are the arithmetic shift by SCALE.
        w_scaled    = w_round[PW-1:SCALE];
        w_acc       = {{3{w_y_cur[WIDTH-1]}}, w_y_cur} + w_scaled;
        w_res       = w_acc[WIDTH-1:0];
        w_sat       = 1'b0;
        if (w_acc > C_MAX) begin
            w_res = C_MAX[WIDTH-1:0];
            w_sat = 1'b1;
        end else if (w_acc < C_MIN) begin
            w_res = C_MIN[WIDTH-1:0];
            w_sat = 1'b1;
        end
    end

    // Fractional bits are discarded by the shift.
    assign w_unused_round = ^w_round[SCALE-1:0];

    // ------------------------------------------------------------------
    // Sample capture, channel state and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch      <= '0;
            r_x       <= '0;
            r_alpha   <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_y[i] <= '0;
            end
        end else if (clr_all) begin
            out_valid <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_y[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_ch    <= in_ch;
                r_x     <= in_data;
                r_alpha <= alpha;
            end
            if (w_calc) begin
                r_y[r_ch] <= w_res;
                out_ch    <= r_ch;
                out_data  <= w_res;
                out_valid <= 1'b1;
            end
            if ((r_state == S_OUT) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef LPF_MC_SATFLAG_EN
    // Sticky flags: only rst clears them, clr_all leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flags <= '0;
        end else if (w_calc && !clr_all && w_sat) begin
            sat_flags[r_ch] <= 1'b1;
        end
    end
`else
    logic w_unused_sat;
    assign w_unused_sat = w_sat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lpf_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpf_mc
// Description : Self-checking bench for lpf_mc (WIDTH=10, SCALE=15, NCH=4).
//               Table of sequential vectors plus hand-written sequences for
//               backpressure, clr_all abort and mid-operation reset.
//               Honors LPF_MC_SATFLAG_EN for the sat_flags port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpf_mc;

    logic              clk;
    logic              rst;
    logic [15:0]       alpha;
    logic              clr_all;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_ch;
    logic signed [9:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_ch;
    logic signed [9:0] out_data;
`ifdef LPF_MC_SATFLAG_EN
    logic [3:0]        sat_flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    lpf_mc #(.WIDTH(10), .SCALE(15), .NCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alpha     (alpha),
        .clr_all   (clr_all),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data)
`ifdef LPF_MC_SATFLAG_EN
        ,
        .sat_flags (sat_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ch;
        int         x;
        int         a;
        int         exp_d;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present a sample and hold it until the accept edge; returns #1 after it.
    task automatic drive_accept(input logic [1:0] ch, input int x, input int a);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = 10'(x);
        alpha    = 16'(a);
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("in_ready_timeout", int'(ok), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        alpha    = '0;
        check("out_valid_after_accept", int'(out_valid), 0);
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 10);
    endtask

    task automatic sample(input string name, input logic [1:0] ch, input int x,
                          input int a, input int exp_d);
        int lat;
        drive_accept(ch, x, a);
        wait_out(lat);
        check({name, "_lat"}, lat, 1);
        check({name, "_data"}, int'(out_data), exp_d);
        check({name, "_ch"}, int'(out_ch), int'(ch));
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Hand-computed expected outputs; vectors run in order and build state.
        vecs[0]  = '{2'd0,  100, 16384,   50};
        vecs[1]  = '{2'd0,  100, 16384,   75};
        vecs[2]  = '{2'd0,  100, 16384,   88};
        vecs[3]  = '{2'd1, -100, 16384,  -50};
        vecs[4]  = '{2'd1,    0, 16384,  -25};
        vecs[5]  = '{2'd0,  100, 16384,   94};
        vecs[6]  = '{2'd2,  511, 49152,  511};
        vecs[7]  = '{2'd3, -512, 65535, -512};
        vecs[8]  = '{2'd1,   37, 32768,   37};
        vecs[9]  = '{2'd1,  500,     0,   37};
        vecs[10] = '{2'd2, -512, 49152, -512};

        rst       = 1'b1;
        alpha     = '0;
        clr_all   = 1'b0;
        in_valid  = 1'b0;
        in_ch     = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_ch", int'(out_ch), 0);
        check("reset_out_data", int'(out_data), 0);
`ifdef LPF_MC_SATFLAG_EN
        check("reset_sat_flags", int'(sat_flags), 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            sample($sformatf("vec%0d", i), vecs[i].ch, vecs[i].x, vecs[i].a, vecs[i].exp_d);
            check($sformatf("vec%0d_idle", i), int'(in_ready), 1);
`ifdef LPF_MC_SATFLAG_EN
            if (i == 6) check("sat_flags_ch2", int'(sat_flags), 4);
`endif
        end
`ifdef LPF_MC_SATFLAG_EN
        check("sat_flags_sticky", int'(sat_flags), 12);
`endif

        // Backpressure: ch0 state 94 -> x=100 gives 97
        out_ready = 1'b0;
        drive_accept(2'd0, 100, 16384);
        wait_out(lat);
        check("bp_lat", lat, 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_data_hold", int'(out_data), 97);
            check("bp_ch_hold", int'(out_ch), 0);
            check("bp_valid_hold", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_idle", int'(in_ready), 1);

        // clr_all while in CALC aborts ch3 x=200
        drive_accept(2'd3, 200, 32768);
        clr_all = 1'b1;
        @(posedge clk); #1;
        clr_all = 1'b0;
        check("clr_idle", int'(in_ready), 1);
        for (int k = 0; k < 3; k++) begin
            check("clr_no_out", int'(out_valid), 0);
            @(posedge clk); #1;
        end
`ifdef LPF_MC_SATFLAG_EN
        check("clr_keeps_flags", int'(sat_flags), 12);
`endif
        sample("clr_ch3", 2'd3, 0, 16384, 0);
        sample("clr_ch0", 2'd0, 0, 32768, 0);

        // Sample offered on the same edge as clr_all must be ignored
        in_valid = 1'b1;
        in_ch    = 2'd1;
        in_data  = 10'sd300;
        alpha    = 16'd32768;
        clr_all  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr_all  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("clr_same_edge_no_out", int'(out_valid), 0);
            check("clr_same_edge_idle", int'(in_ready), 1);
            @(posedge clk); #1;
        end

        // Reset while holding a result in OUT
        out_ready = 1'b0;
        drive_accept(2'd0, 100, 16384);
        wait_out(lat);
        check("rst_pre_valid", int'(out_valid), 1);
        check("rst_pre_data", int'(out_data), 50);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_data", int'(out_data), 0);
`ifdef LPF_MC_SATFLAG_EN
        check("rst_sat_flags", int'(sat_flags), 0);
`endif
        out_ready = 1'b1;
        sample("rst_ch0", 2'd0, 100, 16384, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
